matching_stage_pipe: RTL and testbench

//  Parametrised, registered matching stage for the dictionary compressor. Takes LANES words per beat
//  and classifies each one against a circular FIFO dictionary as full, 3-byte, 2-byte or miss, plus a

---
 rtl/matching_stage_pipe_pkg.sv | 15 +
 rtl/matching_stage_pipe_if.sv | 36 +++
 rtl/matching_stage_pipe_dict_lane_cmp.sv | 45 ++++
 rtl/matching_stage_pipe.sv | 190 +++++++++++++++++++
 tb/tb_matching_stage_pipe.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matching_stage_pipe_pkg.sv
// Shared types for the dictionary matching stage: match classification
// and the byte counts used for the partial compares.
package matching_pkg;

    typedef enum logic [1:0] {
        MT_MISS = 2'b00,
        MT_HALF = 2'b01,
        MT_3B   = 2'b10,
        MT_FULL = 2'b11
    } match_type_e;

    localparam int HALF_BYTES = 2;
    localparam int B3_BYTES   = 3;

endpackage

// File: rtl/matching_stage_pipe_if.sv
// Handshake and result bundle of the matching stage. The slave modport is
// the stage itself; the master modport is the surrounding environment.
interface matching_stage_pipe_if #(
    parameter int LANES      = 2,
    parameter int WORD       = 32,
    parameter int DICT_ENTRY = 16
);
    localparam int LOC_W = $clog2(DICT_ENTRY);

    logic                   i_flush;
    logic                   i_valid;
    logic                   o_ready;
    logic [LANES*WORD-1:0]  i_word;
    logic                   o_valid;
    logic                   i_ready;
    logic [LANES*2-1:0]     o_type;
    logic [LANES*LOC_W-1:0] o_loc;
    logic [LANES-1:0]       o_zero;
    logic [LOC_W:0]         o_dict_count;
    logic                   o_dict_full;
    logic [31:0]            o_stat_full;
    logic [31:0]            o_stat_miss;

    modport master (
        output i_flush, i_valid, i_word, i_ready,
        input  o_ready, o_valid, o_type, o_loc, o_zero,
               o_dict_count, o_dict_full, o_stat_full, o_stat_miss
    );

    modport slave (
        input  i_flush, i_valid, i_word, i_ready,
        output o_ready, o_valid, o_type, o_loc, o_zero,
               o_dict_count, o_dict_full, o_stat_full, o_stat_miss
    );

endinterface

// File: rtl/matching_stage_pipe_dict_lane_cmp.sv
// Compares one word against every dictionary entry and returns the best
// match class; ties resolve to the lowest eligible index.
module dict_lane_cmp
    import matching_pkg::*;
#(
    parameter int WORD       = 32,
    parameter int DICT_ENTRY = 16,
    parameter int LOC_W      = $clog2(DICT_ENTRY)
) (
    input  logic [WORD-1:0]                  word,
    input  logic [DICT_ENTRY-1:0][WORD-1:0]  entries,
    input  logic [DICT_ENTRY-1:0]            eligible,
    output match_type_e                      best_type,
    output logic [LOC_W-1:0]                 best_loc
);
    localparam int HALF_W = HALF_BYTES * 8;
    localparam int B3_W   = B3_BYTES * 8;

    match_type_e entry_type [DICT_ENTRY];

    genvar gi;
    generate
        for (gi = 0; gi < DICT_ENTRY; gi++) begin : g_entry
            assign entry_type[gi] =
                !eligible[gi]                                            ? MT_MISS :
                (entries[gi] == word)                                    ? MT_FULL :
                (entries[gi][WORD-1 -: B3_W] == word[WORD-1 -: B3_W])     ? MT_3B   :
                (entries[gi][WORD-1 -: HALF_W] == word[WORD-1 -: HALF_W]) ? MT_HALF :
                                                                           MT_MISS;
        end
    endgenerate

    // Strictly-greater update keeps the first (lowest) index among equals.
    always_comb begin
        best_type = MT_MISS;
        best_loc  = '0;
        for (int i = 0; i < DICT_ENTRY; i++) begin
            if (entry_type[i] > best_type) begin
                best_type = entry_type[i];
                best_loc  = LOC_W'(i);
            end
        end
    end

endmodule

// File: rtl/matching_stage_pipe.sv
// Registered matching stage: classifies LANES words per beat against a
// circular FIFO dictionary. Optional match statistics under MATCH_STATS_EN.
module matching_stage_pipe
    import matching_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int WORD       = 32,
    parameter int DICT_ENTRY = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    matching_stage_pipe_if.slave bus
);
    localparam int LOC_W = $clog2(DICT_ENTRY);
    localparam logic [LOC_W:0] CNT_MAX = (LOC_W+1)'(DICT_ENTRY);

    logic [DICT_ENTRY-1:0][WORD-1:0] dict_reg;
    logic [DICT_ENTRY-1:0][WORD-1:0] dict_next;
    logic [LOC_W-1:0]                wr_ptr_reg;
    logic [LOC_W-1:0]                wr_ptr_next;
    logic [LOC_W:0]                  count_reg;
    logic [LOC_W:0]                  count_next;
    logic                            o_valid_reg;
    logic [LANES*2-1:0]              type_reg;
    logic [LANES*2-1:0]              type_next;
    logic [LANES*LOC_W-1:0]          loc_reg;
    logic [LANES*LOC_W-1:0]          loc_next;
    logic [LANES-1:0]                zero_reg;
    logic [LANES-1:0]                zero_next;
    logic                            ready;
    logic                            accept;

    assign ready       = !o_valid_reg || bus.i_ready;
    assign accept      = bus.i_valid && ready;
    assign bus.o_ready = ready;

    // Each lane sees the dictionary as left by the lanes before it in the beat.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DICT_ENTRY-1:0][WORD-1:0] view_in;
            logic [DICT_ENTRY-1:0][WORD-1:0] view_out;
            logic [LOC_W-1:0]                ptr_in;
            logic [LOC_W-1:0]                ptr_out;
            logic [LOC_W:0]                  cnt_in;
            logic [LOC_W:0]                  cnt_out;
            logic [WORD-1:0]                 lane_word;
            logic [DICT_ENTRY-1:0]           eligible;
            match_type_e                     cmp_type;
            logic [LOC_W-1:0]                cmp_loc;
            logic                            is_zero;
            logic                            push;

            if (gi == 0) begin : g_head
                // A flush in the accept cycle means the beat starts from an empty dictionary.
                assign view_in = dict_reg;
                assign ptr_in  = bus.i_flush ? '0 : wr_ptr_reg;
                assign cnt_in  = bus.i_flush ? '0 : count_reg;
            end else begin : g_chain
                assign view_in = g_lane[gi-1].view_out;
                assign ptr_in  = g_lane[gi-1].ptr_out;
                assign cnt_in  = g_lane[gi-1].cnt_out;
            end

            assign lane_word = bus.i_word[gi*WORD +: WORD];
            assign is_zero   = (lane_word == '0);

            always_comb begin
                for (int e = 0; e < DICT_ENTRY; e++) begin
                    eligible[e] = ((LOC_W+1)'(e) < cnt_in);
                end
            end

            dict_lane_cmp #(
                .WORD       (WORD),
                .DICT_ENTRY (DICT_ENTRY),
                .LOC_W      (LOC_W)
            ) u_cmp (
                .word      (lane_word),
                .entries   (view_in),
                .eligible  (eligible),
                .best_type (cmp_type),
                .best_loc  (cmp_loc)
            );

            assign push = !is_zero && (cmp_type != MT_FULL);

            always_comb begin
                view_out = view_in;
                if (push) begin
                    view_out[ptr_in] = lane_word;
                end
            end

            assign ptr_out = ptr_in + LOC_W'(push);
            assign cnt_out = (push && (cnt_in != CNT_MAX)) ? cnt_in + (LOC_W+1)'(1) : cnt_in;

            assign type_next[gi*2 +: 2]         = is_zero ? MT_MISS : cmp_type;
            assign loc_next[gi*LOC_W +: LOC_W]  = is_zero ? '0 : cmp_loc;
            assign zero_next[gi]                = is_zero;
        end
    endgenerate

    assign dict_next   = g_lane[LANES-1].view_out;
    assign wr_ptr_next = g_lane[LANES-1].ptr_out;
    assign count_next  = g_lane[LANES-1].cnt_out;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid_reg <= 1'b0;
            type_reg    <= '0;
            loc_reg     <= '0;
            zero_reg    <= '0;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
        end else if (accept) begin
            o_valid_reg <= 1'b1;
            type_reg    <= type_next;
            loc_reg     <= loc_next;
            zero_reg    <= zero_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
        end else begin
            if (bus.i_ready) begin
                o_valid_reg <= 1'b0;
            end
            if (bus.i_flush) begin
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end
        end
    end

    // Entry contents need no reset: only entries below count are ever compared.
    always_ff @(posedge i_clk) begin
        if (!i_reset && accept) begin
            dict_reg <= dict_next;
        end
    end

    assign bus.o_valid      = o_valid_reg;
    assign bus.o_type       = type_reg;
    assign bus.o_loc        = loc_reg;
    assign bus.o_zero       = zero_reg;
    assign bus.o_dict_count = count_reg;
    assign bus.o_dict_full  = (count_reg == CNT_MAX);

`ifdef MATCH_STATS_EN
    logic [31:0]      stat_full_reg;
    logic [31:0]      stat_miss_reg;
    logic [LANES-1:0] lane_full;
    logic [LANES-1:0] lane_miss;

    function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [LANES-1:0] flags);
        logic [32:0] sum;
        sum = {1'b0, base};
        for (int i = 0; i < LANES; i++) begin
            sum = sum + 33'(flags[i]);
        end
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_full[l] = (type_next[l*2 +: 2] == MT_FULL);
            lane_miss[l] = (type_next[l*2 +: 2] == MT_MISS) && !zero_next[l];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stat_full_reg <= '0;
            stat_miss_reg <= '0;
        end else if (accept) begin
            stat_full_reg <= sat_add(bus.i_flush ? 32'h0 : stat_full_reg, lane_full);
            stat_miss_reg <= sat_add(bus.i_flush ? 32'h0 : stat_miss_reg, lane_miss);
        end else if (bus.i_flush) begin
            stat_full_reg <= '0;
            stat_miss_reg <= '0;
        end
    end

    assign bus.o_stat_full = stat_full_reg;
    assign bus.o_stat_miss = stat_miss_reg;
`else
    assign bus.o_stat_full = '0;
    assign bus.o_stat_miss = '0;
`endif

endmodule

// File: tb/tb_matching_stage_pipe.sv
// Bench for matching_stage_pipe: directed vector table, hand sequences for
// fill/wrap and backpressure, then random beats against a list-based model.
module tb_matching_stage_pipe;

    localparam int DE = 16;
`ifdef MATCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matching_stage_pipe_if #(.LANES(2), .WORD(32), .DICT_ENTRY(DE)) bus ();

    matching_stage_pipe #(.LANES(2), .WORD(32), .DICT_ENTRY(DE)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: dictionary slots, fill level, next write slot, stats.
    logic [31:0] m_dict [DE];
    int          m_cnt;
    int          m_wp;
    longint      m_full;
    longint      m_miss;
    logic [3:0]  exp_type;
    logic [7:0]  exp_loc;
    logic [1:0]  exp_zero;

    logic [31:0] pool [8];
    int          pool_wp = 0;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        bit          fl;
        logic [3:0]  t;
        logic [7:0]  loc;
        logic [1:0]  z;
        int          cnt;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp(input longint v);
        if (!STATS_ON) return 32'h0;
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_wp = 0; m_full = 0; m_miss = 0;
    endtask

    task automatic model_beat(input logic [31:0] w0, input logic [31:0] w1, input bit fl);
        logic [31:0] w [2];
        w[0] = w0;
        w[1] = w1;
        if (fl) model_clear();
        exp_type = '0; exp_loc = '0; exp_zero = '0;
        for (int j = 0; j < 2; j++) begin
            int best;
            int loc;
            int score;
            if (w[j] == 32'h0) begin
                exp_zero[j] = 1'b1;
                continue;
            end
            best = 0; loc = 0;
            for (int e = 0; e < m_cnt; e++) begin
                if (m_dict[e] == w[j])                    score = 3;
                else if (m_dict[e][31:8] == w[j][31:8])   score = 2;
                else if (m_dict[e][31:16] == w[j][31:16]) score = 1;
                else                                      score = 0;
                if (score > best) begin
                    best = score;
                    loc  = e;
                end
            end
            exp_type[j*2 +: 2] = 2'(best);
            exp_loc[j*4 +: 4]  = 4'(loc);
            if (best == 3) begin
                m_full++;
            end else begin
                if (best == 0) m_miss++;
                m_dict[m_wp] = w[j];
                m_wp = (m_wp + 1) % DE;
                if (m_cnt < DE) m_cnt++;
            end
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"},     64'(bus.o_dict_count), 64'(m_cnt));
        check({tag, ".full"},      64'(bus.o_dict_full),  64'(m_cnt == DE));
        check({tag, ".stat_full"}, 64'(bus.o_stat_full),  64'(stat_exp(m_full)));
        check({tag, ".stat_miss"}, 64'(bus.o_stat_miss),  64'(stat_exp(m_miss)));
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 64'(bus.o_valid), 64'(1));
        check({tag, ".type"},  64'(bus.o_type),  64'(exp_type));
        check({tag, ".loc"},   64'(bus.o_loc),   64'(exp_loc));
        check({tag, ".zero"},  64'(bus.o_zero),  64'(exp_zero));
        check_state(tag);
    endtask

    task automatic beat(input string tag, input logic [31:0] w0, input logic [31:0] w1, input bit fl);
        bus.i_word  = {w1, w0};
        bus.i_flush = fl;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        model_beat(w0, w1, fl);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        $display("%s: L0=%h L1=%h flush=%0d -> type=%b loc=%h zero=%b count=%0d",
                 tag, w0, w1, fl, bus.o_type, bus.o_loc, bus.o_zero, bus.o_dict_count);
        check_outputs(tag);
    endtask

    task automatic idle(input bit fl);
        bus.i_valid = 1'b0;
        bus.i_flush = fl;
        bus.i_ready = 1'b1;
        if (fl) model_clear();
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        $display("idle: flush=%0d count=%0d", fl, bus.o_dict_count);
        check("idle.valid", 64'(bus.o_valid), 64'(0));
        check_state("idle");
    endtask

    // One-cycle reset; with_beat also offers a beat that the reset must override.
    task automatic do_reset(input bit with_beat);
        bus.i_valid = with_beat;
        bus.i_word  = {32'hDEAD_BEEF, 32'h1234_5678};
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.i_valid = 1'b0;
        model_clear();
        $display("reset: with_beat=%0d valid=%0d count=%0d", with_beat, bus.o_valid, bus.o_dict_count);
        check("reset.valid", 64'(bus.o_valid), 64'(0));
        check("reset.type",  64'(bus.o_type),  64'(0));
        check("reset.loc",   64'(bus.o_loc),   64'(0));
        check("reset.zero",  64'(bus.o_zero),  64'(0));
        check_state("reset");
    endtask

    function automatic logic [31:0] rand_word();
        int sel;
        logic [31:0] w;
        sel = $urandom_range(0, 9);
        if (sel == 0) begin
            w = 32'h0;
        end else if (sel <= 5) begin
            w = pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 2))
                1:       w[7:0]  = 8'($urandom);
                2:       w[15:0] = 16'($urandom);
                default: ;
            endcase
        end else begin
            w = {8'hA0 + 8'($urandom_range(0, 3)), 24'($urandom)};
        end
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0, a1, b0, b1, r0, r1;

        vecs[0] = '{32'h1122_3344, 32'h1122_3344, 1'b0, 4'b1100, 8'h00, 2'b00, 1};
        vecs[1] = '{32'hAABB_CCDD, 32'h0000_0000, 1'b1, 4'b0000, 8'h00, 2'b10, 1};
        vecs[2] = '{32'hAABB_CC00, 32'hAABB_0000, 1'b0, 4'b0110, 8'h00, 2'b00, 3};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000, 8'h00, 2'b11, 3};
        vecs[4] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 4'b1100, 8'h00, 2'b00, 1};
        vecs[5] = '{32'h0000_0006, 32'h0000_0005, 1'b0, 4'b1110, 8'h00, 2'b00, 2};
        vecs[6] = '{32'h0000_0006, 32'h0000_0106, 1'b0, 4'b0111, 8'h01, 2'b00, 3};

        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_word  = '0;
        @(posedge clk); #1;
        do_reset(1'b0);

        // Directed table with constant expectations.
        for (int i = 0; i < 7; i++) begin
            beat($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].fl);
            check($sformatf("vec%0d.tbl_type", i),  64'(bus.o_type),       64'(vecs[i].t));
            check($sformatf("vec%0d.tbl_loc", i),   64'(bus.o_loc),        64'(vecs[i].loc));
            check($sformatf("vec%0d.tbl_zero", i),  64'(bus.o_zero),       64'(vecs[i].z));
            check($sformatf("vec%0d.tbl_count", i), 64'(bus.o_dict_count), 64'(vecs[i].cnt));
            if (i == 4) begin
                check("vec4.tbl_stat_full", 64'(bus.o_stat_full), 64'(STATS_ON ? 1 : 0));
                check("vec4.tbl_stat_miss", 64'(bus.o_stat_miss), 64'(STATS_ON ? 1 : 0));
            end
        end

        // Fill to 16 distinct words, overwrite the oldest, then resend the lost word.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            beat($sformatf("fill%0d", i), {8'(2*i + 1), 24'h123456}, {8'(2*i + 2), 24'h123456}, 1'b0);
            check($sformatf("fill%0d.dict_full", i), 64'(bus.o_dict_full), 64'(i == 7));
        end
        beat("wrap17", {8'd17, 24'h123456}, 32'h0, 1'b0);
        check("wrap17.miss", 64'(bus.o_type[1:0]), 64'(0));
        check("wrap17.count", 64'(bus.o_dict_count), 64'(16));
        beat("resend1", {8'd1, 24'h123456}, 32'h0, 1'b0);
        check("resend1.miss", 64'(bus.o_type[1:0]), 64'(0));
        check("resend1.dict_full", 64'(bus.o_dict_full), 64'(1));

        // Backpressure: result held for three cycles while a new beat waits.
        idle(1'b0);
        a0 = 32'h0BAD_0001; a1 = 32'h0BAD_0002;
        b0 = 32'h0BAD_0001; b1 = 32'h0BAD_0102;
        bus.i_word  = {a1, a0};
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b0;
        model_beat(a0, a1, 1'b0);
        @(posedge clk); #1;
        $display("bp_first: type=%b loc=%h count=%0d", bus.o_type, bus.o_loc, bus.o_dict_count);
        check_outputs("bp_first");
        bus.i_word = {b1, b0};
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp%0d.ready", c), 64'(bus.o_ready), 64'(0));
            @(posedge clk); #1;
            $display("bp_hold%0d: valid=%0d type=%b count=%0d", c, bus.o_valid, bus.o_type, bus.o_dict_count);
            check_outputs($sformatf("bp_hold%0d", c));
        end
        bus.i_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(bus.o_ready), 64'(1));
        model_beat(b0, b1, 1'b0);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        $display("bp_second: type=%b loc=%h count=%0d", bus.o_type, bus.o_loc, bus.o_dict_count);
        check_outputs("bp_second");

        // Random beats, idle cycles and flushes against the model.
        for (int k = 0; k < 8; k++) pool[k] = {8'hA0 + 8'($urandom_range(0, 3)), 24'($urandom)};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle($urandom_range(0, 1) == 1);
            end else begin
                r0 = rand_word();
                r1 = rand_word();
                beat($sformatf("rnd%0d", n), r0, r1, $urandom_range(0, 19) == 0);
                if (r0 != 32'h0) begin
                    pool[pool_wp] = r0;
                    pool_wp = (pool_wp + 1) % 8;
                end
                if (r1 != 32'h0) begin
                    pool[pool_wp] = r1;
                    pool_wp = (pool_wp + 1) % 8;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
